adc_capture_seq: RTL and testbench
==================================

// Module: adc_capture_seq
// PURPOSE
//  Sequencer for triggered ADC capture. Watches the 12-bit ADC stream at a slow trigger rate and
//  detects a step of at least TRIG_DELTA. It then runs a sample divider and captures exactly
//  2**LOG2_N samples, reducing them on the fly to max/min/average.
//  Results are held under a valid/ack handshake. Sits between the ADC input register and the display/out logic.
// PARAMETERS
//  DW          12       ADC sample width
//  LOG2_N      10       log2 of samples per capture (N = 1024)
//  SMP_DIV     98       clocks per sample strobe (>=2)
//  TRIG_PERIOD 100000   clocks per trigger-compare tick (1 ms at 100 MHz, >=2)
//  TRIG_DELTA  150      minimum step (LSB) that counts as a trigger event
//  TRIG_FALL   1        1: trigger on falling step (prev-cur>=DELTA); 0: rising step (cur-prev>=DELTA)
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      synchronous reset, active low
//  data       in   DW     ADC sample, treated as unsigned, sampled on strobes only
//  arm        in   1      1-cycle request: IDLE->ARMED
//  abort      in   1      return to IDLE from any state
//  busy       out  1      high in ARMED or CAPTURE
//  smp_strobe out  1      1-cycle pulse per captured sample
//  res_valid  out  1      results valid, held until res_ack
//  res_ack    in   1      consumes results
//  res_max    out  DW     maximum of capture
//  res_min    out  DW     minimum of capture
//  res_aver   out  DW     sum >> LOG2_N (truncating)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; all counters, prev/cur trigger regs and sum are 0.
//   All outputs are 0, including res_max and res_min.
//  Trigger sampler: free-running counter tcnt 0..TRIG_PERIOD-1, running in all states. tick when tcnt==TRIG_PERIOD-1.
//   On tick: prev<=cur, cur<=data. trig_evt is a registered 1-cycle pulse, asserted the cycle after the tick.
//   It is computed from the updated pair as unsigned compares with no wrap: for a falling step, prev>cur && prev-cur>=TRIG_DELTA.
//   Equality with TRIG_DELTA triggers. trig_evt is honoured only in ARMED and is otherwise ignored (not queued).
//  FSM:
//   IDLE    : arm -> ARMED.
//   ARMED   : trig_evt -> CAPTURE. Entry clears scnt=0, idx=0, sum=0, max=0, min=all-ones.
//   CAPTURE : scnt counts 0..SMP_DIV-1. When scnt==SMP_DIV-1, smp_strobe=1 and data is folded in:
//             max=max(max,data), min=min(min,data), sum+=data (sum width DW+LOG2_N, cannot overflow), idx++.
//             The first strobe occurs SMP_DIV cycles after entering CAPTURE.
//             The strobe with idx==N-1 -> DONE. The next cycle res_valid=1 with the final max/min/aver.
//   DONE    : res_max/min/aver stable while res_valid=1. res_ack -> IDLE, res_valid=0 the next cycle.
//  abort: highest priority; from any state -> IDLE next cycle, res_valid cleared, partial results discarded.
//   res_* keep their last values.
//  arm in any state but IDLE is ignored. arm+abort in the same cycle -> IDLE.
//  res_ack outside DONE is ignored. res_ack+abort -> IDLE.
//  busy and smp_strobe are registered from the state and scnt; no combinational input-to-output path.
//  The sample data value equal to 0 or 2**DW-1 is a legal extreme and must land in min/max exactly.
// CONFIGURATION
//  AUTO_REARM_EN defined: in DONE, res_ack -> ARMED instead of IDLE, so busy=1 the next cycle.
//   The next trig_evt starts a new capture without a further arm pulse. abort still -> IDLE.
//  AUTO_REARM_EN undefined: DONE+res_ack -> IDLE; every capture needs its own arm pulse.
// TESTING  (bench params: LOG2_N=2, SMP_DIV=4, TRIG_PERIOD=8, TRIG_DELTA=150, TRIG_FALL=1)
//  1. Reset mid-CAPTURE -> next cycle busy=0, res_valid=0, res_max=0, res_min=0, res_aver=0, smp_strobe silent.
//  2. arm; data 1000 then 850 on successive ticks -> trig_evt (delta=150, boundary); samples 10,20,30,44
//     -> 4 strobes 4 clocks apart; res_valid 1 cycle after the 4th strobe, max=44, min=10, aver=26.
//  3. arm; step 1000->851 (delta 149) then rising 851->1100 -> no capture, busy stays 1 in ARMED.
//  4. Capture of samples 4095,0,4095,0 -> max=4095, min=0, aver=2047. Hold res_ack=0 for 50 cycles:
//     res_* unchanged, further trig_evt ignored.
//  5. abort on the 2nd strobe cycle -> IDLE next cycle, res_valid never asserts; a fresh arm + capture
//     of 5,5,5,5 -> max=min=aver=5 (no carry-over of the partial sum).
//  6. AUTO_REARM_EN: res_ack in DONE -> busy=1 next cycle; the next valid step starts a capture with no arm pulse.
//     Without the macro -> busy=0 and no capture.

Source files
------------

// File: rtl/adc_capture_seq.sv
// adc_capture_seq: triggered ADC capture sequencer.
// A slow trigger sampler watches the ADC stream for a step of at least TRIG_DELTA.
// Once armed, that step starts a capture of 2**LOG2_N samples, taken one every SMP_DIV clocks.
// The samples are reduced on the fly to max/min/average, which are then held under a valid/ack handshake.
// Optional feature: define AUTO_REARM_EN so that acknowledging a result re-arms the sequencer
// instead of returning it to idle.
module adc_capture_seq #(
  parameter int DW          = 12,
  parameter int LOG2_N      = 10,
  parameter int SMP_DIV     = 98,
  parameter int TRIG_PERIOD = 100000,
  parameter int TRIG_DELTA  = 150,
  parameter int TRIG_FALL   = 1
) (
  input  logic          clk,
  input  logic          rst_n_i,
  input  logic [DW-1:0] data_i,
  input  logic          arm_i,
  input  logic          abort_i,
  output logic          busy_o,
  output logic          smp_strobe_o,
  output logic          res_valid_o,
  input  logic          res_ack_i,
  output logic [DW-1:0] res_max_o,
  output logic [DW-1:0] res_min_o,
  output logic [DW-1:0] res_aver_o
);

  localparam int TW   = (TRIG_PERIOD > 1) ? $clog2(TRIG_PERIOD) : 1;
  localparam int SW   = (SMP_DIV > 1) ? $clog2(SMP_DIV) : 1;
  localparam int SUMW = DW + LOG2_N;
  localparam logic [DW:0]   DELTA_W   = (DW+1)'(TRIG_DELTA);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TRIG_PERIOD - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(SMP_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  // ---------------- trigger sampler ----------------
  logic [TW-1:0] tcnt_q;
  logic [DW-1:0] prev_q, cur_q;
  logic          trig_evt_q;
  logic          tick;
  logic          step_hit;
  logic [DW-1:0] step_diff;

  assign tick = (tcnt_q == TCNT_LAST);

  // Step test against the pair as it will be after this tick (prev<=cur, cur<=data).
  // The magnitude check is only taken when the direction is right, so the subtraction never wraps.
  generate
    if (TRIG_FALL != 0) begin : g_fall
      assign step_diff = cur_q - data_i;
      assign step_hit  = (cur_q > data_i) && ({1'b0, step_diff} >= DELTA_W);
    end else begin : g_rise
      assign step_diff = data_i - cur_q;
      assign step_hit  = (data_i > cur_q) && ({1'b0, step_diff} >= DELTA_W);
    end
  endgenerate

  // Free-running tick counter, prev/cur sample pair and a one-cycle trigger pulse.
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      tcnt_q     <= '0;
      prev_q     <= '0;
      cur_q      <= '0;
      trig_evt_q <= 1'b0;
    end else begin
      tcnt_q     <= tick ? '0 : tcnt_q + TW'(1);
      trig_evt_q <= tick && step_hit;
      if (tick) begin
        prev_q <= cur_q;
        cur_q  <= data_i;
      end
    end
  end

  // ---------------- capture FSM ----------------
  state_t              state_q, state_d;
  logic [SW-1:0]       scnt_q, scnt_d;
  logic [LOG2_N-1:0]   idx_q, idx_d;
  logic [SUMW-1:0]     sum_q, sum_d, sum_f;
  logic [DW-1:0]       max_q, max_d, max_f;
  logic [DW-1:0]       min_q, min_d, min_f;
  logic [DW-1:0]       res_max_q, res_max_d;
  logic [DW-1:0]       res_min_q, res_min_d;
  logic [DW-1:0]       res_aver_q, res_aver_d;
  logic                busy_q, strobe_q, valid_q;

  assign max_f = (data_i > max_q) ? data_i : max_q;
  assign min_f = (data_i < min_q) ? data_i : min_q;
  assign sum_f = sum_q + SUMW'(data_i);

  // Next-state, accumulator and result-latch logic; abort overrides everything.
  always_comb begin
    state_d    = state_q;
    scnt_d     = scnt_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    max_d      = max_q;
    min_d      = min_q;
    res_max_d  = res_max_q;
    res_min_d  = res_min_q;
    res_aver_d = res_aver_q;
    case (state_q)
      S_IDLE: begin
        if (arm_i) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (trig_evt_q) begin
          state_d = S_CAPTURE;
          scnt_d  = '0;
          idx_d   = '0;
          sum_d   = '0;
          max_d   = '0;
          min_d   = '1;
        end
      end
      S_CAPTURE: begin
        if (scnt_q == SCNT_LAST) begin
          scnt_d = '0;
          idx_d  = idx_q + LOG2_N'(1);
          sum_d  = sum_f;
          max_d  = max_f;
          min_d  = min_f;
          if (idx_q == '1) begin
            state_d    = S_DONE;
            res_max_d  = max_f;
            res_min_d  = min_f;
            res_aver_d = sum_f[SUMW-1:LOG2_N];
          end
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      S_DONE: begin
        if (res_ack_i) begin
`ifdef AUTO_REARM_EN
          state_d = S_ARMED;
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_i) begin
      state_d    = S_IDLE;
      res_max_d  = res_max_q;
      res_min_d  = res_min_q;
      res_aver_d = res_aver_q;
    end
  end

  // State, accumulators and registered outputs (derived from next state so they align with it).
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      scnt_q     <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      max_q      <= '0;
      min_q      <= '0;
      res_max_q  <= '0;
      res_min_q  <= '0;
      res_aver_q <= '0;
      busy_q     <= 1'b0;
      strobe_q   <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
      min_q      <= min_d;
      res_max_q  <= res_max_d;
      res_min_q  <= res_min_d;
      res_aver_q <= res_aver_d;
      busy_q     <= (state_d == S_ARMED) || (state_d == S_CAPTURE);
      strobe_q   <= (state_d == S_CAPTURE) && (scnt_d == SCNT_LAST);
      valid_q    <= (state_d == S_DONE);
    end
  end

  assign busy_o       = busy_q;
  assign smp_strobe_o = strobe_q;
  assign res_valid_o  = valid_q;
  assign res_max_o    = res_max_q;
  assign res_min_o    = res_min_q;
  assign res_aver_o   = res_aver_q;

endmodule

// File: tb/tb_adc_capture_seq.sv
// Directed testbench for adc_capture_seq (small parameter set: N=4, SMP_DIV=4, TRIG_PERIOD=8).
// Expectations depend on AUTO_REARM_EN when the design is built with it.
module tb_adc_capture_seq;
  localparam int DW = 12;
`ifdef AUTO_REARM_EN
  localparam logic [31:0] AUTO = 32'd1;
`else
  localparam logic [31:0] AUTO = 32'd0;
`endif

  logic          clk = 1'b0;
  logic          rst_n_i, arm_i, abort_i, res_ack_i;
  logic [DW-1:0] data_i;
  logic          busy_o, smp_strobe_o, res_valid_o;
  logic [DW-1:0] res_max_o, res_min_o, res_aver_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  adc_capture_seq #(
    .DW(DW), .LOG2_N(2), .SMP_DIV(4), .TRIG_PERIOD(8), .TRIG_DELTA(150), .TRIG_FALL(1)
  ) dut (
    .clk(clk), .rst_n_i(rst_n_i), .data_i(data_i), .arm_i(arm_i), .abort_i(abort_i),
    .busy_o(busy_o), .smp_strobe_o(smp_strobe_o), .res_valid_o(res_valid_o),
    .res_ack_i(res_ack_i), .res_max_o(res_max_o), .res_min_o(res_min_o), .res_aver_o(res_aver_o)
  );

  function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until a strobe is seen (bounded); n = cycles advanced.
  task automatic wait_strobe(input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (smp_strobe_o !== 1'b1 && n < 40);
    check({tag, " strobe seen"}, 32'(smp_strobe_o), 32'd1);
  endtask

  // Count strobes and valid cycles over a window.
  task automatic window(input int cycles, output int strobes, output int valids);
    strobes = 0;
    valids  = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (smp_strobe_o === 1'b1) strobes++;
      if (res_valid_o === 1'b1) valids++;
    end
  endtask

  // Settle data at 1000, arm, then present 850 (falling step of exactly 150).
  task automatic arm_trigger(input string tag);
    data_i = 12'd1000;
    repeat (12) step();
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    check({tag, " armed busy"}, 32'(busy_o), 32'd1);
    data_i = 12'd850;
  endtask

  // Feed four samples on the strobes; ends on the first res_valid cycle.
  task automatic run_capture(input string tag, input int s0, input int s1, input int s2, input int s3);
    int n;
    int smp[4];
    smp[0] = s0; smp[1] = s1; smp[2] = s2; smp[3] = s3;
    wait_strobe(tag, n);
    data_i = DW'(smp[0]);
    for (int i = 1; i < 4; i++) begin
      wait_strobe(tag, n);
      check({tag, " strobe spacing"}, 32'(n), 32'd4);
      data_i = DW'(smp[i]);
    end
    step();
    check({tag, " res_valid after last strobe"}, 32'(res_valid_o), 32'd1);
    check({tag, " strobe low in done"}, 32'(smp_strobe_o), 32'd0);
  endtask

  task automatic check_res(input string tag, input int mx, input int mn, input int av);
    check({tag, " res_max"}, 32'(res_max_o), 32'(mx));
    check({tag, " res_min"}, 32'(res_min_o), 32'(mn));
    check({tag, " res_aver"}, 32'(res_aver_o), 32'(av));
  endtask

  task automatic ack_and_idle(input string tag);
    res_ack_i = 1'b1;
    step();
    res_ack_i = 1'b0;
    check({tag, " valid cleared by ack"}, 32'(res_valid_o), 32'd0);
    check({tag, " busy after ack"}, 32'(busy_o), AUTO);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, st, va, good;
    rst_n_i = 1'b0; arm_i = 1'b0; abort_i = 1'b0; res_ack_i = 1'b0; data_i = '0;
    repeat (2) step();
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset strobe", 32'(smp_strobe_o), 32'd0);
    check("reset valid", 32'(res_valid_o), 32'd0);
    check_res("reset", 0, 0, 0);
    rst_n_i = 1'b1;
    step();

    // Boundary-delta trigger and basic capture.
    arm_trigger("t2");
    run_capture("t2", 10, 20, 30, 44);
    check_res("t2", 44, 10, 26);
    step();
    check("t2 valid held", 32'(res_valid_o), 32'd1);
    ack_and_idle("t2");

    // Step of 149 and a rising step must not trigger.
    data_i = 12'd1000;
    repeat (12) step();
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    check("t3 armed", 32'(busy_o), 32'd1);
    data_i = 12'd851;
    window(12, st, va);
    check("t3 delta149 strobes", 32'(st), 32'd0);
    res_ack_i = 1'b1;
    step();
    res_ack_i = 1'b0;
    check("t3 ack ignored busy", 32'(busy_o), 32'd1);
    data_i = 12'd1100;
    window(12, st, va);
    check("t3 rising strobes", 32'(st), 32'd0);
    check("t3 still armed", 32'(busy_o), 32'd1);
    check("t3 no valid", 32'(va), 32'd0);
    arm_i = 1'b1; abort_i = 1'b1;
    step();
    arm_i = 1'b0; abort_i = 1'b0;
    check("t3 arm+abort idle", 32'(busy_o), 32'd0);

    // Reset in the middle of a capture.
    arm_trigger("t1");
    wait_strobe("t1", n);
    rst_n_i = 1'b0;
    step();
    check("t1 busy", 32'(busy_o), 32'd0);
    check("t1 valid", 32'(res_valid_o), 32'd0);
    check_res("t1", 0, 0, 0);
    rst_n_i = 1'b1;
    window(12, st, va);
    check("t1 strobe silent", 32'(st), 32'd0);

    // Extremes, then hold results while a trigger step arrives in DONE.
    arm_trigger("t4");
    run_capture("t4", 4095, 0, 4095, 0);
    check_res("t4", 4095, 0, 2047);
    data_i = 12'd1000;
    good = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 20) data_i = 12'd850;
      step();
      if (res_valid_o === 1'b1 && res_max_o === 12'd4095 && res_min_o === 12'd0 &&
          res_aver_o === 12'd2047 && busy_o === 1'b0 && smp_strobe_o === 1'b0) good++;
    end
    check("t4 stable cycles", 32'(good), 32'd50);
    ack_and_idle("t4");

    // Abort on the second strobe, then a clean capture.
    arm_trigger("t5");
    wait_strobe("t5", n);
    data_i = 12'd100;
    wait_strobe("t5", n);
    data_i = 12'd200;
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("t5 abort busy", 32'(busy_o), 32'd0);
    check("t5 abort valid", 32'(res_valid_o), 32'd0);
    window(12, st, va);
    check("t5 valid never", 32'(va), 32'd0);
    check_res("t5 kept", 4095, 0, 2047);
    arm_trigger("t5b");
    run_capture("t5b", 5, 5, 5, 5);
    check_res("t5b", 5, 5, 5);
    ack_and_idle("t5b");

    // Behaviour after ack: re-arm only when built with the auto re-arm option.
    arm_trigger("t6");
    run_capture("t6", 7, 7, 7, 7);
    check_res("t6", 7, 7, 7);
    res_ack_i = 1'b1;
    step();
    res_ack_i = 1'b0;
    check("t6 busy after ack", 32'(busy_o), AUTO);
    data_i = 12'd1000;
    repeat (12) step();
    data_i = 12'd850;
    window(24, st, va);
    check("t6 capture without arm", 32'(st > 0), AUTO);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("t6 abort idle", 32'(busy_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
